// File: rtl/coeff_bank.sv
// Eight-bank coefficient store: 64 packed tap-pair words per filter, streamed in by a loader
// and read back through one shared address with a single cycle of latency.
module coeff_bank #(
  parameter int COEFF_W = 18
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                coeffaddress,
  output logic [2*COEFF_W-1:0]      coeff0,
  output logic [2*COEFF_W-1:0]      coeff1,
  output logic [2*COEFF_W-1:0]      coeff2,
  output logic [2*COEFF_W-1:0]      coeff3,
  output logic [2*COEFF_W-1:0]      coeff4,
  output logic [2*COEFF_W-1:0]      coeff5,
  output logic [2*COEFF_W-1:0]      coeff6,
  output logic [2*COEFF_W-1:0]      coeff7,
  input  logic                      load_start,
  input  logic signed [COEFF_W-1:0] load_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic                      load_busy,
  output logic                      load_done,
  output logic [1:0]                load_state
);

  localparam int WORD_W = 2 * COEFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [6:0]          tap;
  logic [2:0]          filt;
  logic [COEFF_W-1:0]  holding;
  logic [WORD_W-1:0]   mem [8][64];
  logic [WORD_W-1:0]   rd  [8];
  logic                xfer;
  logic                wr_en;

  // Handshake: a coefficient moves when load_valid and load_ready are both high at a
  // rising edge; a simultaneous load_start wins and the offered coefficient is dropped.
  assign xfer  = load_valid && load_ready && !load_start;
  assign wr_en = xfer && tap[0] && !reset;

  assign load_state = state;

  // Memory has no reset so it maps onto block RAM; the read below sees the pre-write word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[filt][tap[6:1]] <= {load_data, holding};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 8; b++) rd[b] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) rd[b] <= mem[b][coeffaddress];
    end
  end

  assign coeff0 = rd[0];
  assign coeff1 = rd[1];
  assign coeff2 = rd[2];
  assign coeff3 = rd[3];
  assign coeff4 = rd[4];
  assign coeff5 = rd[5];
  assign coeff6 = rd[6];
  assign coeff7 = rd[7];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tap        <= '0;
      filt       <= '0;
      holding    <= '0;
      load_ready <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else if (load_start) begin
      // Restart from any state; a half-packed even tap is abandoned.
      state      <= LOAD;
      tap        <= '0;
      filt       <= '0;
      holding    <= '0;
      load_ready <= 1'b1;
      load_busy  <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
        end
        LOAD: begin
          if (xfer) begin
            if (!tap[0]) holding <= load_data;
            if (tap == 7'd127) begin
              tap <= '0;
              if (filt == 3'd7) begin
                state      <= DONE;
                load_ready <= 1'b0;
                load_busy  <= 1'b1;
                load_done  <= 1'b1;
              end else begin
                filt <= filt + 3'd1;
              end
            end else begin
              tap <= tap + 7'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_bank.sv
// Directed bench for coeff_bank: full loads, read sweeps, read-first collision,
// restart, reset abort and idle handshake behaviour.
module tb_coeff_bank;

  logic               clock;
  logic               reset;
  logic [5:0]         coeffaddress;
  logic [35:0]        coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic               load_start;
  logic signed [17:0] load_data;
  logic               load_valid;
  logic               load_ready;
  logic               load_busy;
  logic               load_done;
  logic [1:0]         load_state;

  logic [35:0] cf [8];
  logic [35:0] exp_q [$];
  int          errors;
  int          checks;

  coeff_bank #(.COEFF_W(18)) dut (
    .clock(clock), .reset(reset), .coeffaddress(coeffaddress),
    .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .coeff4(coeff4), .coeff5(coeff5), .coeff6(coeff6), .coeff7(coeff7),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .load_state(load_state)
  );

  assign cf[0] = coeff0;
  assign cf[1] = coeff1;
  assign cf[2] = coeff2;
  assign cf[3] = coeff3;
  assign cf[4] = coeff4;
  assign cf[5] = coeff5;
  assign cf[6] = coeff6;
  assign cf[7] = coeff7;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] pair(input logic [17:0] hi, input logic [17:0] lo);
    return {hi, lo};
  endfunction

  // Tap t of filter f carries (f<<8)+t; word a holds taps 2a (low) and 2a+1 (high).
  function automatic logic [35:0] ref_word(input int f, input int a);
    logic [17:0] lo;
    lo = 18'(f * 256 + 2 * a);
    return {lo + 18'd1, lo};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic xfer(input logic [17:0] d);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    while (!load_ready && n < 8) begin
      tick();
      n++;
    end
    check("xfer_ready", {35'd0, load_ready}, 36'd1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic chk_read(input string tag, input int bank, input int addr, input logic [35:0] exp);
    coeffaddress = 6'(addr);
    tick();
    check(tag, cf[bank], exp);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 64; a++) begin
      coeffaddress = 6'(a);
      for (int b = 0; b < 8; b++) exp_q.push_back(ref_word(b, a));
      tick();
      for (int b = 0; b < 8; b++) check(tag, cf[b], exp_q.pop_front());
    end
  endtask

  task automatic full_load(input bit zero, input bit toggle, input bit chk034);
    int          idx, cyc, rdy_cnt;
    bit          v, hs, busy_bad, done_early;
    logic [17:0] d;
    idx = 0; cyc = 0; rdy_cnt = 0; busy_bad = 0; done_early = 0;
    start_load();
    while (idx < 1024 && cyc < 4200) begin
      v = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      d = zero ? 18'd0 : 18'((idx / 128) * 256 + (idx % 128));
      load_valid = v;
      load_data  = v ? d : 18'h15555;
      if (load_ready) rdy_cnt++;
      if (!load_busy) busy_bad = 1'b1;
      if (load_done)  done_early = 1'b1;
      hs = v && load_ready;
      tick();
      cyc++;
      if (hs) idx++;
      if (chk034 && hs && idx == 2) check("rw_same_old", coeff0, 36'd0);
      if (chk034 && hs && idx == 3) check("rw_same_new", coeff0, pair(18'h00001, 18'h00000));
    end
    load_valid = 1'b0;
    check("xfer_count", 36'(idx), 36'd1024);
    check("busy_during_load", {35'd0, busy_bad}, 36'd0);
    check("done_early", {35'd0, done_early}, 36'd0);
    if (!toggle) check("ready_cycles", 36'(rdy_cnt), 36'd1024);
    check("done_pulse", {35'd0, load_done}, 36'd1);
    check("done_ready", {35'd0, load_ready}, 36'd0);
    check("done_busy", {35'd0, load_busy}, 36'd1);
    tick();
    check("done_clear", {35'd0, load_done}, 36'd0);
    check("idle_busy", {35'd0, load_busy}, 36'd0);
    check("idle_state", {34'd0, load_state}, 36'd0);
  endtask

  initial begin
    logic [17:0] d;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    coeffaddress = '0;
    load_start = 1'b0;
    load_data = '0;
    load_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", {35'd0, load_ready}, 36'd0);
    check("rst_busy", {35'd0, load_busy}, 36'd0);
    check("rst_done", {35'd0, load_done}, 36'd0);
    check("rst_state", {34'd0, load_state}, 36'd0);
    for (int b = 0; b < 8; b++) check("rst_coeff", cf[b], 36'd0);

    // Clear every word, then the reference load with a read-first collision on bank 0 word 0.
    full_load(1'b1, 1'b0, 1'b0);
    coeffaddress = 6'd0;
    full_load(1'b0, 1'b0, 1'b1);
    chk_read("read_addr5", 3, 5, pair(18'd779, 18'd778));
    sweep("sweep_cont");

    // Restart after 10 transfers: the next pair lands in filter 0 word 0.
    start_load();
    for (int i = 0; i < 10; i++) xfer(18'h3F000 + 18'(i));
    start_load();
    check("restart_state", {34'd0, load_state}, 36'd1);
    xfer(18'h00AAA);
    xfer(18'h00BBB);
    chk_read("restart_w0", 0, 0, pair(18'h00BBB, 18'h00AAA));
    chk_read("restart_w1", 0, 1, pair(18'h3F003, 18'h3F002));
    chk_read("restart_w4", 0, 4, pair(18'h3F009, 18'h3F008));

    // Reset after 300 transfers of marked data.
    start_load();
    for (int i = 0; i < 300; i++) begin
      d = 18'h20000 | 18'((i / 128) * 256 + (i % 128));
      xfer(d);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {35'd0, load_busy}, 36'd0);
    check("abort_ready", {35'd0, load_ready}, 36'd0);
    for (int b = 0; b < 8; b++) check("abort_coeff", cf[b], 36'd0);
    chk_read("abort_b1a10", 1, 10, pair(18'h20000 | 18'd277, 18'h20000 | 18'd276));
    chk_read("abort_b2a21", 2, 21, pair(18'h20000 | 18'd555, 18'h20000 | 18'd554));
    chk_read("abort_b2a22", 2, 22, pair(18'd557, 18'd556));
    chk_read("abort_b2a63", 2, 63, pair(18'd639, 18'd638));

    // A valid pulse without load_start must not transfer or write.
    coeffaddress = 6'd0;
    load_valid = 1'b1;
    load_data = 18'h3FFFF;
    repeat (3) begin
      tick();
      check("idle_valid_ready", {35'd0, load_ready}, 36'd0);
      check("idle_valid_state", {34'd0, load_state}, 36'd0);
    end
    load_valid = 1'b0;
    chk_read("idle_valid_mem", 0, 0, pair(18'h20001, 18'h20000));

    // Throttled load restores the reference contents.
    full_load(1'b0, 1'b1, 1'b0);
    sweep("sweep_toggle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
